// File: rtl/modulator_pwm_multi_if.sv
// BRAM-style register port between the PS and the PWM modulator.
//   addr : byte address (word index is addr[15:2])
//   din  : write data from the PS
//   dout : read data to the PS, one cycle after a sampled read
//   en   : access strobe
//   we   : byte write enables; all zero with en high is a read
interface modulator_pwm_multi_if;
  logic [15:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        en;
  logic [3:0]  we;

  modport master (output addr, din, en, we, input dout);
  modport slave  (input addr, din, en, we, output dout);
endinterface

// File: rtl/modulator_pwm_multi.sv
// Multi-channel PWM modulator with double-buffered period/duty per channel,
// sticky period-end flags and a maskable level interrupt.
//   pl_clk0    : system clock, rising edge
//   pl_reset_n : synchronous active-low reset
//   pl_bram    : register port (slave side)
//   pwm_o      : registered PWM outputs, one per channel
//   pl_int_o   : registered |(STATUS & IRQ_MASK)

// One PWM channel: counter, active period/duty and output compare.
module modulator_pwm_multi_ch #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] period_sh,
  input  logic [CNT_WIDTH-1:0] duty_sh,
  output logic                 pwm,
  output logic                 wrap
);
  logic [CNT_WIDTH-1:0] cnt, period_a, duty_a;

  assign wrap = en && (cnt == period_a);

  // While disabled the active registers track the shadows every cycle, so
  // the first period after enabling uses whatever the shadows hold then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      period_a <= '0;
      duty_a   <= '0;
      pwm      <= 1'b0;
    end else begin
      pwm <= en && (cnt < duty_a);
      if (!en || wrap) begin
        cnt      <= '0;
        period_a <= period_sh;
        duty_a   <= duty_sh;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module modulator_pwm_multi #(
  parameter int CH_NUM    = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  pl_clk0,
  input  logic                  pl_reset_n,
  modulator_pwm_multi_if.slave  pl_bram,
  output logic [CH_NUM-1:0]     pwm_o,
  output logic                  pl_int_o
);
  logic [CH_NUM-1:0]                ctrl, status, irq_mask, wrap, status_clr;
  logic [CH_NUM-1:0][CNT_WIDTH-1:0] period_sh, duty_sh;
  logic [13:0]                      word;
  logic [31:0]                      wmask, rdata;
  logic                             wr, rd;
  logic                             unused;

  assign word   = pl_bram.addr[15:2];
  assign wr     = pl_bram.en && (pl_bram.we != 4'b0);
  assign rd     = pl_bram.en && (pl_bram.we == 4'b0);
  assign unused = ^{pl_bram.addr[1:0], pl_bram.din};

  always_comb begin
    for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{pl_bram.we[b]}};
  end

  // Clear only bits written with 1 inside an enabled byte.
  assign status_clr = (wr && word == 14'd1) ?
                      (pl_bram.din[CH_NUM-1:0] & wmask[CH_NUM-1:0]) : '0;

  always_ff @(posedge pl_clk0) begin
    if (!pl_reset_n) begin
      ctrl      <= '0;
      status    <= '0;
      irq_mask  <= '0;
      period_sh <= '0;
      duty_sh   <= '0;
    end else begin
      // A wrap in the same cycle as a clear keeps the flag set.
      status <= (status & ~status_clr) | wrap;
      if (wr) begin
        if (word == 14'd0)
          ctrl <= (ctrl & ~wmask[CH_NUM-1:0]) | (pl_bram.din[CH_NUM-1:0] & wmask[CH_NUM-1:0]);
        if (word == 14'd2)
          irq_mask <= (irq_mask & ~wmask[CH_NUM-1:0]) | (pl_bram.din[CH_NUM-1:0] & wmask[CH_NUM-1:0]);
        for (int c = 0; c < CH_NUM; c++) begin
          if (word == 14'(4 + 2*c))
            period_sh[c] <= (period_sh[c] & ~wmask[CNT_WIDTH-1:0]) |
                            (pl_bram.din[CNT_WIDTH-1:0] & wmask[CNT_WIDTH-1:0]);
          if (word == 14'(5 + 2*c))
            duty_sh[c]   <= (duty_sh[c] & ~wmask[CNT_WIDTH-1:0]) |
                            (pl_bram.din[CNT_WIDTH-1:0] & wmask[CNT_WIDTH-1:0]);
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (word)
      14'd0:   rdata = 32'(ctrl);
      14'd1:   rdata = 32'(status);
      14'd2:   rdata = 32'(irq_mask);
      default: ;
    endcase
    for (int c = 0; c < CH_NUM; c++) begin
      if (word == 14'(4 + 2*c)) rdata = 32'(period_sh[c]);
      if (word == 14'(5 + 2*c)) rdata = 32'(duty_sh[c]);
    end
  end

  // Read data comes from pre-edge state, so a same-cycle write reads old.
  always_ff @(posedge pl_clk0) begin
    if (!pl_reset_n) begin
      pl_bram.dout <= '0;
      pl_int_o     <= 1'b0;
    end else begin
      if (rd) pl_bram.dout <= rdata;
      pl_int_o <= |(status & irq_mask);
    end
  end

  modulator_pwm_multi_ch #(.CNT_WIDTH(CNT_WIDTH)) u_ch [CH_NUM-1:0] (
    .clk       (pl_clk0),
    .rst_n     (pl_reset_n),
    .en        (ctrl),
    .period_sh (period_sh),
    .duty_sh   (duty_sh),
    .pwm       (pwm_o),
    .wrap      (wrap)
  );
endmodule

// File: tb/tb_modulator_pwm_multi.sv
// Scoreboard bench: a behavioural model updates on every clock edge and
// queues expected read data; a negedge monitor compares dout, pwm_o and
// pl_int_o against the model. Directed steps add a few absolute checks.
module tb_modulator_pwm_multi;
  localparam int CH = 4;
  localparam int W  = 16;
  localparam int unsigned CHM = (1 << CH) - 1;
  localparam int unsigned WM  = (W == 32) ? 32'hFFFF_FFFF : ((1 << W) - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] pwm_o;
  logic          pl_int_o;
  int            tests = 0;
  int            fails = 0;

  modulator_pwm_multi_if bus();

  modulator_pwm_multi #(.CH_NUM(CH), .CNT_WIDTH(W)) dut (
    .pl_clk0    (clk),
    .pl_reset_n (rst_n),
    .pl_bram    (bus),
    .pwm_o      (pwm_o),
    .pl_int_o   (pl_int_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int unsigned m_ctrl, m_status, m_mask;
  int unsigned m_psh [CH];
  int unsigned m_dsh [CH];
  int unsigned m_pa  [CH];
  int unsigned m_da  [CH];
  int unsigned m_pos [CH];   // position within the current period
  logic [CH-1:0] m_pwm;
  logic          m_int;
  logic [31:0]   rdq [$];

  function automatic int unsigned bmask(logic [3:0] w);
    int unsigned m = 0;
    for (int b = 0; b < 4; b++) if (w[b]) m |= 32'hFF << (8*b);
    return m;
  endfunction

  function automatic int unsigned mread(int unsigned a);
    int unsigned wd = a >> 2;
    if (wd == 0) return m_ctrl;
    if (wd == 1) return m_status;
    if (wd == 2) return m_mask;
    if (wd >= 4 && (wd - 4) / 2 < CH)
      return ((wd - 4) % 2 == 1) ? m_dsh[(wd-4)/2] : m_psh[(wd-4)/2];
    return 0;
  endfunction

  always @(posedge clk) begin : model
    int unsigned bm, d, wd, wb, clr;
    logic [CH-1:0] pn;
    if (!rst_n) begin
      m_ctrl = 0; m_status = 0; m_mask = 0; m_pwm = '0; m_int = 1'b0;
      for (int c = 0; c < CH; c++) begin
        m_psh[c] = 0; m_dsh[c] = 0; m_pa[c] = 0; m_da[c] = 0; m_pos[c] = 0;
      end
    end else begin
      wd = 32'(bus.addr) >> 2;
      bm = bmask(bus.we);
      d  = bus.din;
      if (bus.en && bus.we == 4'b0) rdq.push_back(mread(32'(bus.addr)));
      wb = 0;
      for (int c = 0; c < CH; c++) begin
        pn[c] = m_ctrl[c] && (m_pos[c] < m_da[c]);
        if (!m_ctrl[c] || m_pos[c] == m_pa[c]) begin
          if (m_ctrl[c]) wb |= (1 << c);
          m_pos[c] = 0; m_pa[c] = m_psh[c]; m_da[c] = m_dsh[c];
        end else begin
          m_pos[c]++;
        end
      end
      m_int = |(m_status & m_mask);
      m_pwm = pn;
      clr = 0;
      if (bus.en && bus.we != 4'b0) begin
        if (wd == 0) m_ctrl = ((m_ctrl & ~bm) | (d & bm)) & CHM;
        if (wd == 1) clr = d & bm & CHM;
        if (wd == 2) m_mask = ((m_mask & ~bm) | (d & bm)) & CHM;
        if (wd >= 4 && (wd - 4) / 2 < CH) begin
          if ((wd - 4) % 2 == 1) m_dsh[(wd-4)/2] = ((m_dsh[(wd-4)/2] & ~bm) | (d & bm)) & WM;
          else                   m_psh[(wd-4)/2] = ((m_psh[(wd-4)/2] & ~bm) | (d & bm)) & WM;
        end
      end
      m_status = (m_status & ~clr) | wb;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    chk("pwm_o", 64'(pwm_o), 64'(m_pwm));
    chk("pl_int_o", 64'(pl_int_o), 64'(m_int));
    if (rdq.size() > 0) begin
      e = rdq.pop_front();
      chk("dout", 64'(bus.dout), 64'(e));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] w = 4'hF);
    @(negedge clk);
    bus.addr = a; bus.din = d; bus.we = w; bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0; bus.we = 4'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    @(negedge clk);
    bus.addr = a; bus.we = 4'b0; bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int hi;
    logic [15:0] a;
    bus.addr = '0; bus.din = '0; bus.we = '0; bus.en = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // Reset state: every register reads 0.
    chk("rst_pwm", 64'(pwm_o), 0);
    chk("rst_int", 64'(pl_int_o), 0);
    chk("rst_dout", 64'(bus.dout), 0);
    for (int i = 0; i < 12; i++) rd(16'(4*i));
    rd(16'h0100);

    // CH0 P=9 D=3: first pulse one edge after the enable edge, then 3/7.
    wr(16'h10, 9);
    wr(16'h14, 3);
    wr(16'h00, 1);
    chk("ch0_pre", 64'(pwm_o[0]), 0);
    @(negedge clk);
    chk("ch0_first", 64'(pwm_o[0]), 1);
    hi = 32'(pwm_o[0]);
    repeat (9) begin @(negedge clk); hi += 32'(pwm_o[0]); end
    chk("ch0_hi_10", hi, 3);
    hi = 0;
    repeat (20) begin @(negedge clk); hi += 32'(pwm_o[0]); end
    chk("ch0_hi_20", hi, 6);
    rd(16'h04);

    // CH1 duty update mid-period.
    wr(16'h18, 9);
    wr(16'h1C, 3);
    wr(16'h00, 3);
    idle(4);
    wr(16'h1C, 7);
    idle(30);

    // Boundaries: duty 0, duty > period, period 0.
    wr(16'h20, 9);  wr(16'h24, 0);
    wr(16'h28, 9);  wr(16'h2C, 12);
    wr(16'h00, 32'hF);
    idle(25);
    chk("duty0_low", 64'(pwm_o[2]), 0);
    chk("duty_gt_hi", 64'(pwm_o[3]), 1);
    wr(16'h28, 0);  wr(16'h2C, 1);
    idle(15);
    chk("per0_hi", 64'(pwm_o[3]), 1);

    // Interrupt masking and W1C.
    wr(16'h04, 32'hF);
    wr(16'h08, 32'h2);
    idle(15);
    wr(16'h04, 32'h2);
    rd(16'h04);
    idle(12);
    wr(16'h18, 0);  wr(16'h1C, 1);
    idle(15);
    wr(16'h04, 32'h2);
    rd(16'h04);
    @(negedge clk);
    chk("w1c_set_wins", 64'(bus.dout[1]), 1);
    chk("int_ch1", 64'(pl_int_o), 1);

    // Byte enables and out-of-range accesses.
    wr(16'h10, 32'hFFFF_FFFF, 4'b0001);
    rd(16'h10);
    chk("byte_en", 64'(bus.dout), 64'h0000_00FF);
    wr(16'h0100, 32'hFFFF_FFFF);
    rd(16'h0100);
    chk("oob_read", 64'(bus.dout), 0);
    rd(16'h13);

    // Mid-period reset.
    wr(16'h10, 9);
    idle(5);
    pulse_reset();
    chk("rst_mid_pwm", 64'(pwm_o), 0);
    chk("rst_mid_int", 64'(pl_int_o), 0);
    idle(20);
    chk("idle_after_rst", 64'(pwm_o), 0);
    rd(16'h00);

    // Randomized traffic, small values so periods wrap often.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          a = 16'(($urandom_range(0, 13) * 4) | $urandom_range(0, 3));
          if ($urandom_range(0, 15) == 0) a = 16'($urandom);
          wr(a, ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 20),
             4'($urandom_range(1, 15)));
        end
        4, 5, 6: rd(16'($urandom_range(0, 13) * 4));
        7, 8:    idle($urandom_range(1, 8));
        default: if ($urandom_range(0, 9) == 0) pulse_reset(); else idle(1);
      endcase
    end
    idle(5);
    chk("rdq_empty", rdq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
